// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage F/D/E/M/W ARM pipeline: per-port E forwarding,
// store-data forwarding, multi-cycle load-use stalls and multiply occupancy stalls.
module hazard_ctrl_mc #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned MUL_LAT  = 3
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic [NUM_RD*REG_AW-1:0]   RAD,
  input  logic [NUM_RD-1:0]          RAValidD,
  input  logic [NUM_RD*REG_AW-1:0]   RAE,
  input  logic [REG_AW-1:0]          WA3E,
  input  logic [REG_AW-1:0]          WA3M,
  input  logic [REG_AW-1:0]          WA3W,
  input  logic                       RegWriteE,
  input  logic                       RegWriteM,
  input  logic                       RegWriteW,
  input  logic                       MemtoRegE,
  input  logic                       MemtoRegW,
  input  logic                       MemWriteM,
  input  logic [REG_AW-1:0]          RA2M,
  input  logic                       PCSrcE,
  input  logic                       MulStartE,
  output logic                       StallF,
  output logic                       StallD,
  output logic                       StallE,
  output logic                       FlushD,
  output logic                       FlushE,
  output logic                       FlushM,
  output logic [2*NUM_RD-1:0]        ForwardE,
  output logic                       ForwardM,
  output logic                       MulBusy
);

  localparam int unsigned LCW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam int unsigned MCW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);
  localparam logic [REG_AW-1:0] PC_IDX = '1;

  logic [LCW-1:0] ldcnt, ldcnt_nxt;
  logic [MCW-1:0] mcnt, mcnt_nxt;
  logic           ldhit, mul_busy, br, ldstall, flush_e_raw;
  logic [2*NUM_RD-1:0] fwd_raw;

  // M has priority over W; R15 is never forwarded because the PC read is synthesised.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] a);
    if ((a == WA3M) && RegWriteM && (a != PC_IDX))      fwd_sel = 2'b10;
    else if ((a == WA3W) && RegWriteW && (a != PC_IDX)) fwd_sel = 2'b01;
    else                                                fwd_sel = 2'b00;
  endfunction

  always_comb begin
    fwd_raw = '0;
    ldhit   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      fwd_raw[2*i +: 2] = fwd_sel(RAE[i*REG_AW +: REG_AW]);
      if (RAValidD[i] && (RAD[i*REG_AW +: REG_AW] == WA3E))
        ldhit = 1'b1;
    end
    ldhit = ldhit & MemtoRegE & RegWriteE;
  end

  // A busy multiplier owns E, so a branch there is ignored; a branch overrides load stalls.
  assign mul_busy    = (mcnt != '0);
  assign br          = PCSrcE & ~mul_busy;
  assign ldstall     = ((ldhit & ~mul_busy) | (ldcnt != '0)) & ~br;
  assign flush_e_raw = (ldstall & ~mul_busy) | br;

  always_comb begin
    ldcnt_nxt = ldcnt;
    mcnt_nxt  = mcnt;
    if (ldhit && !PCSrcE && !mul_busy) ldcnt_nxt = LCW'(LOAD_LAT - 1);
    else if (br)                       ldcnt_nxt = '0;
    else if (ldcnt != '0)              ldcnt_nxt = ldcnt - LCW'(1);
    if (MulStartE && !mul_busy && !flush_e_raw) mcnt_nxt = MCW'(MUL_LAT - 1);
    else if (mcnt != '0)                        mcnt_nxt = mcnt - MCW'(1);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      ldcnt <= '0;
      mcnt  <= '0;
    end else begin
      ldcnt <= ldcnt_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // All outputs are held quiet while reset is asserted, whatever the inputs do.
  assign StallF   = RSTn & (ldstall | mul_busy);
  assign StallD   = RSTn & (ldstall | mul_busy);
  assign StallE   = RSTn & mul_busy;
  assign FlushM   = RSTn & mul_busy;
  assign MulBusy  = RSTn & mul_busy;
  assign FlushE   = RSTn & flush_e_raw;
  assign FlushD   = RSTn & br;
  assign ForwardE = RSTn ? fwd_raw : '0;
  assign ForwardM = RSTn & (RA2M == WA3W) & MemWriteM & MemtoRegW & RegWriteW & (RA2M != PC_IDX);

endmodule
